// File: rtl/lc3_regfile_sb.sv
// LC-3 general-purpose register file with two write ports, optional
// write-to-read bypass, a per-register busy scoreboard and the NZP
// condition-code register.
module lc3_regfile_sb #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [READ_PORTS*ADDR_W-1:0] i_rd_addr,
    output logic [READ_PORTS*DATA_W-1:0] o_rd_data,
    output logic [READ_PORTS-1:0]        o_rd_busy,
    input  logic                         i_wa_en,
    input  logic [ADDR_W-1:0]            i_wa_addr,
    input  logic [DATA_W-1:0]            i_wa_data,
    input  logic                         i_wa_cc,
    input  logic                         i_wb_en,
    input  logic [ADDR_W-1:0]            i_wb_addr,
    input  logic [DATA_W-1:0]            i_wb_data,
    input  logic                         i_wb_cc,
    input  logic                         i_iss_en,
    input  logic [ADDR_W-1:0]            i_iss_addr,
    output logic [2:0]                   o_nzp,
    output logic [2**ADDR_W-1:0]         o_busy_vec,
    output logic                         o_collide
);

    localparam int unsigned NREGS = 2**ADDR_W;

    if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_read_ports
        $error("lc3_regfile_sb: READ_PORTS must be in 1..4");
    end

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [2:0]        r_nzp;
    logic              r_collide;

    logic              w_same_addr;
    logic              w_b_commit;
    logic              w_collide_d;
    logic [2:0]        w_nzp_d;
    logic [NREGS-1:0]  w_busy_d;

    // Port A wins a same-address write; B is dropped and flagged.
    assign w_same_addr = (i_wa_addr == i_wb_addr);
    assign w_b_commit  = i_wb_en & ~(i_wa_en & w_same_addr);
    assign w_collide_d = i_wa_en & i_wb_en & w_same_addr;

    function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] d);
        logic n;
        logic z;
        n = d[DATA_W-1];
        z = (d == '0);
        return {n, z, ~n & ~z};
    endfunction

    // Register storage: commit A always, B only when not shadowed by A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_b_commit) begin
                r_regs[i_wb_addr] <= i_wb_data;
            end
            if (i_wa_en) begin
                r_regs[i_wa_addr] <= i_wa_data;
            end
        end
    end

    // Condition-code source select: A first, then a surviving B.
    always_comb begin
        w_nzp_d = r_nzp;
        if (i_wa_en && i_wa_cc) begin
            w_nzp_d = cc_of(i_wa_data);
        end else if (w_b_commit && i_wb_cc) begin
            w_nzp_d = cc_of(i_wb_data);
        end
    end

    // Scoreboard next state: writes clear, issue sets and wins a tie.
    always_comb begin
        w_busy_d = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if ((i_wa_en && (i_wa_addr == ADDR_W'(i))) ||
                (w_b_commit && (i_wb_addr == ADDR_W'(i)))) begin
                w_busy_d[i] = 1'b0;
            end
            if (i_iss_en && (i_iss_addr == ADDR_W'(i))) begin
                w_busy_d[i] = 1'b1;
            end
        end
    end

    // NZP, scoreboard and collision pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nzp     <= 3'b010;
            r_busy    <= '0;
            r_collide <= 1'b0;
        end else begin
            r_nzp     <= w_nzp_d;
            r_busy    <= w_busy_d;
            r_collide <= w_collide_d;
        end
    end

    assign o_nzp      = r_nzp;
    assign o_busy_vec = r_busy;
    assign o_collide  = r_collide;

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];

        if (BYPASS != 0) begin : g_bypass
            logic w_hit_a;
            logic w_hit_b;
            assign w_hit_a = i_wa_en & (i_wa_addr == w_ra);
            assign w_hit_b = i_wb_en & (i_wb_addr == w_ra);
            assign o_rd_data[k*DATA_W +: DATA_W] = w_hit_a ? i_wa_data :
                                                   w_hit_b ? i_wb_data : r_regs[w_ra];
            // A write landing this cycle resolves the hazard for the reader.
            assign o_rd_busy[k] = r_busy[w_ra] & ~(w_hit_a | w_hit_b);
        end else begin : g_stored
            assign o_rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
            assign o_rd_busy[k] = r_busy[w_ra];
        end
    end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Scoreboard bench for lc3_regfile_sb: one bypassing and one non-bypassing
// instance share stimulus; a reference model predicts both.
module tb_lc3_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  rd_addr;
    logic        wa_en, wa_cc, wb_en, wb_cc, iss_en;
    logic [2:0]  wa_addr, wb_addr, iss_addr;
    logic [15:0] wa_data, wb_data;

    logic [31:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [2:0]  nzp_b, nzp_n;
    logic [7:0]  busy_b, busy_n;
    logic        collide_b, collide_n;

    always #5 clk = ~clk;

    lc3_regfile_sb #(.DATA_W(16), .ADDR_W(3), .READ_PORTS(2), .BYPASS(1)) u_dut_byp (
        .clk(clk), .reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
        .o_rd_busy(rd_busy_b), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wa_cc(wa_cc), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_wb_cc(wb_cc), .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_nzp(nzp_b),
        .o_busy_vec(busy_b), .o_collide(collide_b)
    );

    lc3_regfile_sb #(.DATA_W(16), .ADDR_W(3), .READ_PORTS(2), .BYPASS(0)) u_dut_raw (
        .clk(clk), .reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
        .o_rd_busy(rd_busy_n), .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wa_cc(wa_cc), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_wb_cc(wb_cc), .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_nzp(nzp_n),
        .o_busy_vec(busy_n), .o_collide(collide_n)
    );

    typedef struct packed {
        logic [31:0] data_b;
        logic [31:0] data_n;
        logic [1:0]  rbusy_b;
        logic [1:0]  rbusy_n;
        logic [2:0]  nzp;
        logic [7:0]  busy;
        logic        collide;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: architectural state after the most recent edge.
    logic [15:0] m_regs [8];
    bit          m_busy [8];
    logic [2:0]  m_nzp;
    bit          m_collide;

    function automatic logic [2:0] cc(input logic [15:0] d);
        if (d == 16'd0) return 3'b010;
        if (d >= 16'h8000) return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'd0;
            m_busy[i] = 1'b0;
        end
        m_nzp     = 3'b010;
        m_collide = 1'b0;
    endtask

    task automatic model_edge();
        bit drop_b;
        drop_b = wa_en && wb_en && (wa_addr == wb_addr);
        if (wb_en && !drop_b) begin
            m_regs[wb_addr] = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (wa_en) begin
            m_regs[wa_addr] = wa_data;
            m_busy[wa_addr] = 1'b0;
        end
        if (iss_en) m_busy[iss_addr] = 1'b1;
        if (wa_en && wa_cc) m_nzp = cc(wa_data);
        else if (wb_en && wb_cc && !drop_b) m_nzp = cc(wb_data);
        m_collide = drop_b;
    endtask

    task automatic push_expect();
        exp_t        e;
        logic [2:0]  a;
        logic [15:0] v;
        bit          hit;
        for (int k = 0; k < 2; k++) begin
            a   = rd_addr[k*3 +: 3];
            hit = 1'b0;
            v   = m_regs[a];
            if (wa_en && wa_addr == a) begin
                v = wa_data;
                hit = 1'b1;
            end else if (wb_en && wb_addr == a) begin
                v = wb_data;
                hit = 1'b1;
            end
            e.data_b[k*16 +: 16] = v;
            e.data_n[k*16 +: 16] = m_regs[a];
            e.rbusy_b[k]         = m_busy[a] && !hit;
            e.rbusy_n[k]         = m_busy[a];
        end
        for (int i = 0; i < 8; i++) e.busy[i] = m_busy[i];
        e.nzp     = m_nzp;
        e.collide = m_collide;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        wa_en = 0; wa_cc = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_cc = 0; wb_addr = 0; wb_data = 0;
        iss_en = 0; iss_addr = 0;
    endtask

    task automatic step();
        push_expect();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data_byp", rd_data_b, e.data_b);
                chk("rd_data_raw", rd_data_n, e.data_n);
                chk("rd_busy_byp", {30'd0, rd_busy_b}, {30'd0, e.rbusy_b});
                chk("rd_busy_raw", {30'd0, rd_busy_n}, {30'd0, e.rbusy_n});
                chk("nzp_byp", {29'd0, nzp_b}, {29'd0, e.nzp});
                chk("nzp_raw", {29'd0, nzp_n}, {29'd0, e.nzp});
                chk("busy_vec_byp", {24'd0, busy_b}, {24'd0, e.busy});
                chk("busy_vec_raw", {24'd0, busy_n}, {24'd0, e.busy});
                chk("collide_byp", {31'd0, collide_b}, {31'd0, e.collide});
                chk("collide_raw", {31'd0, collide_n}, {31'd0, e.collide});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        rd_addr = 6'd0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // Read every register after reset.
        for (int i = 0; i < 8; i += 2) begin
            rd_addr = {3'(i + 1), 3'(i)};
            step();
        end

        // Write R3 via A, read back next cycle.
        wa_en = 1; wa_addr = 3; wa_data = 16'h1234; wa_cc = 1;
        rd_addr = {3'd0, 3'd3};
        step();
        idle();
        step();

        // Same-cycle bypass on port 1.
        wa_en = 1; wa_addr = 5; wa_data = 16'hBEEF;
        rd_addr = {3'd5, 3'd0};
        step();
        idle();
        step();

        // Collision on R2.
        wa_en = 1; wa_addr = 2; wa_data = 16'h0001; wa_cc = 1;
        wb_en = 1; wb_addr = 2; wb_data = 16'h8000; wb_cc = 1;
        rd_addr = {3'd2, 3'd2};
        step();
        idle();
        step();
        step();

        // NZP source selection.
        wb_en = 1; wb_addr = 7; wb_data = 16'hFFFF; wb_cc = 1;
        step();
        idle();
        wa_en = 1; wa_addr = 1; wa_data = 16'h0005; wa_cc = 0;
        step();
        wa_en = 1; wa_addr = 1; wa_data = 16'h0000; wa_cc = 1;
        step();
        idle();
        step();

        // Scoreboard on R4.
        rd_addr = {3'd0, 3'd4};
        iss_en = 1; iss_addr = 4;
        step();
        idle();
        step();
        wa_en = 1; wa_addr = 4; wa_data = 16'h4444;
        step();
        idle();
        step();
        iss_en = 1; iss_addr = 4; wa_en = 1; wa_addr = 4; wa_data = 16'h0044;
        step();
        idle();
        step();

        // Async reset between edges, right after a collision.
        wa_en = 1; wa_addr = 6; wa_data = 16'h0066;
        wb_en = 1; wb_addr = 6; wb_data = 16'h6600;
        step();
        idle();
        wa_en = 1; wa_addr = 1; wa_data = 16'h0077; wa_cc = 1;
        rd_addr = {3'd0, 3'd0};
        #1;
        reset = 1'b1;
        model_reset();
        step();
        idle();
        reset = 1'b0;
        rd_addr = {3'd6, 3'd1};
        step();
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            wa_en    = ($urandom_range(0, 1) == 1);
            wa_addr  = 3'($urandom_range(0, 7));
            wa_cc    = ($urandom_range(0, 1) == 1);
            wa_data  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : 3'($urandom_range(0, 7));
            wb_cc    = ($urandom_range(0, 1) == 1);
            wb_data  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = 3'($urandom_range(0, 7));
            rd_addr  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) rd_addr[2:0] = wa_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[5:3] = wb_addr;
            step();
        end

        idle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_regfile_sb.md
# lc3_regfile_sb

Parametrised general-purpose register file for the pipelined LC-3 core, replacing the single-write, two-read file. It provides a configurable number of combinational read ports, two write ports (ALU writeback A, memory/load writeback B), optional write-to-read bypass, a per-register busy scoreboard for hazard detection, and the architectural NZP condition-code register. It sits between decode (reads, issue), and the two writeback stages.

## Interface
Parameters:
- DATA_W, 16, register width
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- READ_PORTS, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- rd_addr  in  READ_PORTS*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  READ_PORTS*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  READ_PORTS  register at rd_addr[k] has a pending producer
- wa_en, wa_addr, wa_data, wa_cc  in  1, ADDR_W, DATA_W, 1  write port A (ALU); wa_cc = update NZP
- wb_en, wb_addr, wb_data, wb_cc  in  1, ADDR_W, DATA_W, 1  write port B (load); wb_cc = update NZP
- iss_en, iss_addr  in  1, ADDR_W  issue: mark destination register busy
- nzp  out  3  condition codes {N,Z,P}, registered
- busy_vec  out  NREGS  raw scoreboard bits
- collide  out  1  registered one-cycle pulse: A and B wrote the same address last cycle

## Operation
- Storage: NREGS x DATA_W flops, written on rising clk.
- Write priority: A and B to different addresses both commit. Same address: A commits, B is dropped, collide pulses for one cycle after the edge.
- NZP: selects one CC source per cycle. A if wa_en&wa_cc, else B if wb_en&wb_cc and B not dropped by a collision, else unchanged. N = data[DATA_W-1]; Z = (data==0); P = ~N&~Z. Exactly one bit set at all times.
- Scoreboard: iss_en sets busy[iss_addr]. Any committed write to addr clears busy[addr]. Issue and write to the same addr in one cycle: busy stays set (new producer wins).
- Read, BYPASS=1: for each port, if wa_en & wa_addr==rd_addr, return wa_data. Else if wb_en & wb_addr==rd_addr, return wb_data. Else return the stored value.
- Read, BYPASS=1, busy: rd_busy[k] = busy[rd_addr] & ~(matching committed write this cycle). An iss_en to the same addr in the same cycle does not affect rd_busy until the next cycle.
- Read, BYPASS=0: rd_data is the stored value; rd_busy[k] = busy[rd_addr].
- All read paths are purely combinational. No R0 special-casing; every register is writable.

## Timing
- Reset (async assert, sync release): all registers 0, busy_vec 0, nzp 3'b010, collide 0. rd_data then reads 0 and rd_busy reads 0.
- Write latency: 1 edge to storage. Read latency: 0 cycles, same-cycle with BYPASS=1.
- Reset asserted mid-operation discards the pending write, issue and collide pulse immediately.
- Out-of-range READ_PORTS is a parameter error and is flagged by elaboration check.

## Test plan
- Reset then read all: every rd_data = 0, nzp = 010, busy_vec = 0; write R3=16'h1234 via A, next cycle rd_addr0=3 gives 16'h1234.
- Bypass: BYPASS=1, wa_en R5=16'hBEEF with rd_addr1=5 in the same cycle, so rd_data1 = 16'hBEEF before the edge. Repeat with BYPASS=0: old value 0 is returned.
- Collision: A writes R2=16'h0001 and B writes R2=16'h8000 with both cc set. Result: R2=16'h0001, nzp=001, collide=1 for exactly one cycle.
- NZP source: B-only write 16'hFFFF with wb_cc, giving nzp=100. Then wa_en with wa_cc=0 leaves nzp=100. Then A write 0 with cc gives nzp=010.
- Scoreboard: iss R4, then busy_vec[4]=1 and rd_busy=1 for a read of R4. In the writeback cycle of R4 (BYPASS=1), rd_busy=0 combinationally. Issue R4 and write R4 in the same cycle leaves busy_vec[4]=1.
- Async reset mid-write: assert reset between edges while wa_en is pending, so the registers stay 0 and no collide pulse appears after release.
